// File: rtl/spi_sram_device_if.sv
// Serial SRAM link signals between a master and the spi_sram_device responder.
interface spi_sram_device_if;
  logic cs_n;
  logic mosi;
  logic miso;
  logic cmd_err;

  modport master (output cs_n, output mosi, input miso, input cmd_err);
  modport slave  (input cs_n, input mosi, output miso, output cmd_err);
endinterface

// File: rtl/spi_sram_device.sv
// 23LC-style serial SRAM responder (mode 0, MSB first, sequential mode) on the system clock.
// Byte-addressed async-read memory; READ/WRITE/RDMR/WRMR commands, cmd_err on unknown opcodes.
module spi_sram_device #(
  parameter int unsigned ADDR_BITS = 16,
  parameter logic [7:0]  MODE_RST  = 8'h40
) (
  input  logic             clk,
  input  logic             arst_n,
  spi_sram_device_if.slave bus
);

  localparam int unsigned DEPTH   = 1 << ADDR_BITS;
  localparam int unsigned SHIFT_W = (ADDR_BITS > 8) ? ADDR_BITS : 8;
  localparam int unsigned CNT_W   = 5;

  localparam logic [2:0] ST_CMD    = 3'd0;
  localparam logic [2:0] ST_ADDR   = 3'd1;
  localparam logic [2:0] ST_RDATA  = 3'd2;
  localparam logic [2:0] ST_WDATA  = 3'd3;
  localparam logic [2:0] ST_RDMR   = 3'd4;
  localparam logic [2:0] ST_WRMR   = 3'd5;
  localparam logic [2:0] ST_IGNORE = 3'd6;

  localparam logic [7:0] OP_WRMR = 8'h01;
  localparam logic [7:0] OP_WR   = 8'h02;
  localparam logic [7:0] OP_RD   = 8'h03;
  localparam logic [7:0] OP_RDMR = 8'h05;

  logic [2:0]           state_q, state_d;
  logic                 is_rd_q, is_rd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SHIFT_W-2:0]   shift_q, shift_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [7:0]           mode_q, mode_d;
  logic [7:0]           rd_q, rd_d;
  logic                 miso_q, miso_d;
  logic                 cmd_err_q, cmd_err_d;

  logic [7:0]           mem [DEPTH];
  logic [SHIFT_W-1:0]   shift_in_c;
  logic [7:0]           byte_in_c;
  logic [ADDR_BITS-1:0] addr_in_c;
  logic [ADDR_BITS-1:0] addr_inc_c;
  logic [ADDR_BITS-1:0] rd_addr_c;
  logic [7:0]           rd_byte_c;
  logic                 mem_we_c;

  // Incoming bit appended to the history so the final bit of a field is usable on its own edge.
  assign shift_in_c = {shift_q, bus.mosi};
  assign byte_in_c  = shift_in_c[7:0];
  assign addr_in_c  = shift_in_c[ADDR_BITS-1:0];
  assign addr_inc_c = addr_q + ADDR_BITS'(1);
  assign rd_addr_c  = (state_q == ST_ADDR) ? addr_in_c : addr_inc_c;
  assign rd_byte_c  = mem[rd_addr_c];

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    is_rd_d   = is_rd_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    mode_d    = mode_q;
    rd_d      = rd_q;
    miso_d    = 1'b0;
    cmd_err_d = 1'b0;
    mem_we_c  = 1'b0;

    if (bus.cs_n) begin
      state_d = ST_CMD;
      cnt_d   = '0;
      shift_d = '0;
    end else begin
      shift_d = shift_in_c[SHIFT_W-2:0];
      cnt_d   = cnt_q + CNT_W'(1);
      case (state_q)
        ST_CMD: begin
          if (cnt_q == CNT_W'(7)) begin
            cnt_d = '0;
            case (byte_in_c)
              OP_RD:   begin state_d = ST_ADDR; is_rd_d = 1'b1; end
              OP_WR:   begin state_d = ST_ADDR; is_rd_d = 1'b0; end
              OP_RDMR: begin
                state_d = ST_RDMR;
                miso_d  = mode_q[7];
                rd_d    = {mode_q[6:0], 1'b0};
              end
              OP_WRMR: state_d = ST_WRMR;
              default: begin state_d = ST_IGNORE; cmd_err_d = 1'b1; end
            endcase
          end
        end
        ST_ADDR: begin
          if (cnt_q == CNT_W'(23)) begin
            cnt_d  = '0;
            addr_d = addr_in_c;
            if (is_rd_q) begin
              state_d = ST_RDATA;
              miso_d  = rd_byte_c[7];
              rd_d    = {rd_byte_c[6:0], 1'b0};
            end else begin
              state_d = ST_WDATA;
            end
          end
        end
        ST_RDATA: begin
          // Byte boundary: next byte's MSB goes out with no gap.
          if (cnt_q == CNT_W'(7)) begin
            cnt_d  = '0;
            addr_d = addr_inc_c;
            miso_d = rd_byte_c[7];
            rd_d   = {rd_byte_c[6:0], 1'b0};
          end else begin
            miso_d = rd_q[7];
            rd_d   = {rd_q[6:0], 1'b0};
          end
        end
        ST_WDATA: begin
          if (cnt_q == CNT_W'(7)) begin
            cnt_d    = '0;
            mem_we_c = 1'b1;
            addr_d   = addr_inc_c;
          end
        end
        ST_RDMR: begin
          if (cnt_q == CNT_W'(7)) begin
            cnt_d  = '0;
            miso_d = mode_q[7];
            rd_d   = {mode_q[6:0], 1'b0};
          end else begin
            miso_d = rd_q[7];
            rd_d   = {rd_q[6:0], 1'b0};
          end
        end
        ST_WRMR: begin
          if (cnt_q == CNT_W'(7)) begin
            cnt_d   = '0;
            mode_d  = byte_in_c;
            state_d = ST_IGNORE;
          end
        end
        ST_IGNORE: cnt_d = cnt_q;
        default: begin
          state_d = ST_IGNORE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= ST_CMD;
      is_rd_q   <= 1'b0;
      cnt_q     <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      mode_q    <= MODE_RST;
      rd_q      <= '0;
      miso_q    <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_rd_q   <= is_rd_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      mode_q    <= mode_d;
      rd_q      <= rd_d;
      miso_q    <= miso_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[addr_q] <= byte_in_c;
  end

  assign bus.miso    = miso_q;
  assign bus.cmd_err = cmd_err_q;

endmodule
